// File: rtl/traffic_light_nway.sv
// rtl/traffic_light_nway.sv - N-way round-robin traffic light controller
// Pedestrian all-red walk phase and maintenance yellow flash mode.
module traffic_light_nway #(
  parameter int N_WAYS     = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int FLASH_CYC  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_WAYS-1:0]           car_req,
  input  logic                        ped_req,
  input  logic                        flash_en,
  output logic [3*N_WAYS-1:0]         lights,
  output logic                        walk,
  output logic [$clog2(N_WAYS)-1:0]   active_way
);

  localparam int AW   = $clog2(N_WAYS);
  localparam int MAX1 = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int MAX2 = (ALLRED_CYC > WALK_CYC) ? ALLRED_CYC : WALK_CYC;
  localparam int MAX3 = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int MAXC = (MAX3 > FLASH_CYC) ? MAX3 : FLASH_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_ALL_RED = 3'd0,
    S_GREEN   = 3'd1,
    S_YELLOW  = 3'd2,
    S_WALK    = 3'd3,
    S_FLASH   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       active_q, active_d;
  logic [N_WAYS-1:0]   pending_q, pending_d;
  logic                ped_q, ped_d;
  logic                flash_lit_q, flash_lit_d;

  logic [AW-1:0]       next_way;
  logic [N_WAYS-1:0]   active_mask;
  logic [N_WAYS-1:0]   clr_mask;
  logic                ped_clr;
  logic                expired;
  logic                others_waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ALL_RED;
      cnt_q       <= CW'(ALLRED_CYC);
      active_q    <= '0;
      pending_q   <= '0;
      ped_q       <= 1'b0;
      flash_lit_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      ped_q       <= ped_d;
      flash_lit_q <= flash_lit_d;
    end
  end

  // Round-robin search starting after the current way; current way is checked last.
  always_comb begin
    int idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    next_way = active_q;
    for (int i = 1; i <= N_WAYS; i++) begin
      idx = int'(active_q) + i;
      if (idx >= N_WAYS) idx = idx - N_WAYS;
      if (!found && pending_q[idx]) begin
        found    = 1'b1;
        next_way = AW'(idx);
      end
    end
  end

  assign active_mask    = N_WAYS'(1) << active_q;
  assign others_waiting = (|(pending_q & ~active_mask)) | ped_q;
  assign expired        = (cnt_q == CW'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    flash_lit_d = flash_lit_q;
    clr_mask    = '0;
    ped_clr     = 1'b0;

    if (flash_en) begin
      if (state_q != S_FLASH) begin
        state_d     = S_FLASH;
        cnt_d       = CW'(FLASH_CYC);
        flash_lit_d = 1'b1;
      end else if (expired) begin
        cnt_d       = CW'(FLASH_CYC);
        flash_lit_d = ~flash_lit_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      case (state_q)
        S_ALL_RED: begin
          if (!expired) begin
            cnt_d = cnt_q - CW'(1);
          end else if (ped_q) begin
            state_d = S_WALK;
            cnt_d   = CW'(WALK_CYC);
            ped_clr = 1'b1;
          end else begin
            state_d  = S_GREEN;
            cnt_d    = CW'(GREEN_CYC);
            active_d = next_way;
            clr_mask = N_WAYS'(1) << next_way;
          end
        end
        S_GREEN: begin
          // Counter parks at 1 once minimum green is served.
          if (!expired) begin
            cnt_d = cnt_q - CW'(1);
          end else if (others_waiting) begin
            state_d = S_YELLOW;
            cnt_d   = CW'(YELLOW_CYC);
          end
        end
        S_YELLOW, S_WALK: begin
          if (!expired) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = S_ALL_RED;
            cnt_d   = CW'(ALLRED_CYC);
          end
        end
        default: begin
          state_d = S_ALL_RED;
          cnt_d   = CW'(ALLRED_CYC);
        end
      endcase
    end

    pending_d = (pending_q | car_req) & ~clr_mask;
    ped_d     = (ped_q | ped_req) & ~ped_clr;
  end

  always_comb begin
    lights = '0;
    for (int k = 0; k < N_WAYS; k++) begin
      lights[3*k +: 3] = 3'b100;
      case (state_q)
        S_GREEN:  if (int'(active_q) == k) lights[3*k +: 3] = 3'b001;
        S_YELLOW: if (int'(active_q) == k) lights[3*k +: 3] = 3'b010;
        S_FLASH:  lights[3*k +: 3] = flash_lit_q ? 3'b010 : 3'b000;
        default:  lights[3*k +: 3] = 3'b100;
      endcase
    end
  end

  assign walk       = (state_q == S_WALK);
  assign active_way = active_q;

endmodule
